// File: rtl/c17_bist_pkg.sv
// c17_bist_pkg: shared state encoding, default constants and signature type for the c17 BIST loop
package c17_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SIG_W_DEF = 16;
  localparam logic [SIG_W_DEF-1:0] DEF_POLY = 16'h1021;
  localparam logic [SIG_W_DEF-1:0] DEF_SEED = 16'hFFFF;
  typedef logic [SIG_W_DEF-1:0] sig_t;
endpackage

// File: rtl/c17_misr.sv
// c17_misr: multiple-input signature register with synchronous load of the seed and accept enable
module c17_misr
  import c17_bist_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int RESP_W = 2,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [RESP_W-1:0] resp,
  output logic [SIG_W-1:0]  sig,
  output logic [SIG_W-1:0]  nxt
);
  assign nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
  // signature register: seed on load, fold one response vector per enabled cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= SEED;
    else if (load) sig <= SEED;
    else if (en) sig <= nxt;
endmodule

// File: rtl/c17_sig_analyzer.sv
// c17_sig_analyzer: MISR response compactor with run control and golden compare; C17_SA_ONES_EN adds a ones-count check
module c17_sig_analyzer
  import c17_bist_pkg::*;
#(
  parameter int RESP_W = 2,
  parameter int SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(DEF_SEED),
  parameter int NUM_PAT = 64,
  localparam int CW = $clog2(NUM_PAT + 1),
  localparam int OW = $clog2(NUM_PAT * RESP_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  input  logic [SIG_W-1:0]  golden,
`ifdef C17_SA_ONES_EN
  input  logic [OW-1:0]     golden_ones,
  output logic [OW-1:0]     ones_cnt,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CW-1:0]     pat_cnt
);
  state_t state;
  logic [SIG_W-1:0] sig_nxt;
  logic ld, acc, last, ones_ok;
  assign ld = start && state != RUN;
  assign acc = state == RUN && resp_valid && !abort;
  assign last = pat_cnt == CW'(NUM_PAT - 1);

  c17_misr #(.SIG_W(SIG_W), .RESP_W(RESP_W), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk(clk), .rst_n(rst_n), .load(ld), .en(acc), .resp(resp), .sig(signature), .nxt(sig_nxt)
  );

`ifdef C17_SA_ONES_EN
  logic [OW-1:0] ones_nxt;
  assign ones_nxt = ones_cnt + OW'($countones(resp));
  assign ones_ok = ones_nxt == golden_ones;
  // ones counter runs alongside the signature and clears with it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ones_cnt <= '0;
    else if (ld) ones_cnt <= '0;
    else if (acc) ones_cnt <= ones_nxt;
`else
  assign ones_ok = 1'b1;
`endif

  // run control: the verdict is registered from the signature the last vector produces
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      pat_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= RUN;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            pat_cnt <= '0;
          end
        RUN:
          if (abort) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (resp_valid) begin
            pat_cnt <= pat_cnt + CW'(1);
            if (last) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
              pass <= sig_nxt == golden && ones_ok;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_c17_sig_analyzer.sv
// tb_c17_sig_analyzer: scoreboard bench for c17_sig_analyzer with NUM_PAT=1 and NUM_PAT=64 instances
module tb_c17_sig_analyzer;
  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          cnt;
    int          ones;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, abort = 1'b0, resp_valid = 1'b0;
  logic [1:0] resp = 2'b00;
  logic [15:0] golden = 16'h0000;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] sig_a, sig_b;
  logic [0:0] cnt_a;
  logic [6:0] cnt_b;
`ifdef C17_SA_ONES_EN
  logic [1:0] golden_ones_a = 2'd0;
  logic [7:0] golden_ones_b = 8'd0;
  logic [1:0] ones_a;
  logic [7:0] ones_b;
`endif
  int total = 0, bad = 0;
  exp_t qa[$], qb[$];
  logic done_qa = 1'b0, done_qb = 1'b0;

  always #5 clk = ~clk;

  c17_sig_analyzer #(.NUM_PAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .resp_valid(resp_valid),
    .resp(resp), .golden(golden),
`ifdef C17_SA_ONES_EN
    .golden_ones(golden_ones_a), .ones_cnt(ones_a),
`endif
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pat_cnt(cnt_a)
  );

  c17_sig_analyzer #(.NUM_PAT(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .resp_valid(resp_valid),
    .resp(resp), .golden(golden),
`ifdef C17_SA_ONES_EN
    .golden_ones(golden_ones_b), .ones_cnt(ones_b),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pat_cnt(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [1:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
  endfunction

  function automatic logic [1:0] pat(input int i);
    return 2'((i * 3) ^ (i >> 3));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_a && !done_qa) begin
      if (qa.size() == 0) chk("a_unexpected_done", 32'(done_a), 32'(0));
      else begin
        e = qa.pop_front();
        chk("a_sig", 32'(sig_a), 32'(e.sig));
        chk("a_pass", 32'(pass_a), 32'(e.pass));
        chk("a_cnt", 32'(cnt_a), 32'(e.cnt));
        chk("a_busy_low", 32'(busy_a), 32'(0));
`ifdef C17_SA_ONES_EN
        chk("a_ones", 32'(ones_a), 32'(e.ones));
`endif
      end
    end
    if (rst_n && done_b && !done_qb) begin
      if (qb.size() == 0) chk("b_unexpected_done", 32'(done_b), 32'(0));
      else begin
        e = qb.pop_front();
        chk("b_sig", 32'(sig_b), 32'(e.sig));
        chk("b_pass", 32'(pass_b), 32'(e.pass));
        chk("b_cnt", 32'(cnt_b), 32'(e.cnt));
        chk("b_busy_low", 32'(busy_b), 32'(0));
`ifdef C17_SA_ONES_EN
        chk("b_ones", 32'(ones_b), 32'(e.ones));
`endif
      end
    end
    done_qa = done_a;
    done_qb = done_b;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy_b"}, 32'(busy_b), 32'(0));
    chk({tag, "_done_b"}, 32'(done_b), 32'(0));
    chk({tag, "_pass_b"}, 32'(pass_b), 32'(0));
    chk({tag, "_sig_b"}, 32'(sig_b), 32'hFFFF);
    chk({tag, "_cnt_b"}, 32'(cnt_b), 32'(0));
`ifdef C17_SA_ONES_EN
    chk({tag, "_ones_b"}, 32'(ones_b), 32'(0));
`endif
  endtask

  initial begin
    logic [15:0] s;
    int ones;
    repeat (2) @(negedge clk);
    chk("rst_busy_a", 32'(busy_a), 32'(0));
    chk("rst_done_a", 32'(done_a), 32'(0));
    chk("rst_sig_a", 32'(sig_a), 32'hFFFF);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    golden = 16'hEFDF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a1_busy", 32'(busy_a), 32'(1));
    resp_valid = 1'b1;
    resp = 2'b00;
    qa.push_back('{16'hEFDF, 1'b1, 1, 0});
    @(negedge clk);
    resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a2_done_cleared", 32'(done_a), 32'(0));
    chk("a2_pass_cleared", 32'(pass_a), 32'(0));
    chk("a2_reseed", 32'(sig_a), 32'hFFFF);
    resp_valid = 1'b1;
    resp = 2'b11;
    qa.push_back('{16'hEFDC, 1'b0, 1, 2});
    @(negedge clk);
    resp_valid = 1'b0;
    s = 16'hFFFF;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      s = misr(s, pat(i));
      ones += int'($countones(pat(i)));
    end
    golden = s;
`ifdef C17_SA_ONES_EN
    golden_ones_b = 8'(ones);
`endif
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_busy_after_start", 32'(busy_b), 32'(1));
    for (int i = 0; i < 64; i++) begin
      resp_valid = 1'b1;
      resp = pat(i);
      if (i == 63) qb.push_back('{s, 1'b1, 64, ones});
      @(negedge clk);
      resp_valid = 1'b0;
      start_b = (i == 20);
      if (i == 62) begin
        chk("b_done_early", 32'(done_b), 32'(0));
        chk("b_cnt_63", 32'(cnt_b), 32'(63));
      end
      if (i == 20) chk("b_start_in_run_cnt", 32'(cnt_b), 32'(21));
      @(negedge clk);
      start_b = 1'b0;
    end
    resp_valid = 1'b1;
    resp = 2'b11;
    repeat (2) @(negedge clk);
    resp_valid = 1'b0;
    chk("b_done_hold", 32'(done_b), 32'(1));
    chk("b_cnt_sat", 32'(cnt_b), 32'(64));
    chk("b_sig_hold", 32'(sig_b), 32'(s));
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    s = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      resp_valid = 1'b1;
      resp = pat(i + 5);
      s = misr(s, pat(i + 5));
      @(negedge clk);
    end
    abort = 1'b1;
    resp = 2'b11;
    @(negedge clk);
    abort = 1'b0;
    resp_valid = 1'b0;
    chk("ab_busy", 32'(busy_b), 32'(0));
    chk("ab_done", 32'(done_b), 32'(0));
    chk("ab_cnt", 32'(cnt_b), 32'(10));
    chk("ab_sig", 32'(sig_b), 32'(s));
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("rs_sig", 32'(sig_b), 32'hFFFF);
    chk("rs_cnt", 32'(cnt_b), 32'(0));
    chk("rs_busy", 32'(busy_b), 32'(1));
    for (int i = 0; i < 30; i++) begin
      resp_valid = 1'b1;
      resp = 2'b01;
      @(negedge clk);
    end
    resp_valid = 1'b0;
    chk("mid_cnt", 32'(cnt_b), 32'(30));
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_drain", 32'(qa.size()), 32'(0));
    chk("b_drain", 32'(qb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/c17_sig_analyzer.md
# c17_sig_analyzer

Response-side companion to the c17 stimulus path: a multiple-input signature register (MISR) that compacts a stream of circuit output vectors (N22/N23 style response bits) into a signature. After a programmed number of patterns it compares the signature against a golden value and reports pass/fail. It sits at the output end of the c17 built-in self-test loop, opposite the pattern source.

## Interface
Parameters:
- RESP_W, 2, width of one response vector (c17 outputs).
- SIG_W, 16, signature register width; RESP_W ≤ SIG_W.
- POLY, 16'h1021, feedback polynomial (x^16+x^12+x^5+1), low SIG_W bits used.
- SEED, 16'hFFFF, signature value loaded on start.
- NUM_PAT, 64, number of response vectors per run; ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE or DONE.
- abort  in  1  cancel a run in progress.
- resp_valid  in  1  resp carries a vector this cycle.
- resp  in  RESP_W  circuit response vector.
- golden  in  SIG_W  expected signature; must be stable while done=1.
- busy  out  1  run in progress (RUN state).
- done  out  1  run complete; held until next start.
- pass  out  1  signature==golden; valid only while done=1.
- signature  out  SIG_W  current MISR contents.
- pat_cnt  out  clog2(NUM_PAT+1)  vectors accepted this run.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start → RUN; signature←SEED, pat_cnt←0.
- RUN: each cycle with resp_valid=1: signature←{signature[SIG_W-2:0],0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extend(resp); pat_cnt++.
- RUN: accepting vector number NUM_PAT → DONE; pass←(next signature==golden).
- RUN: start ignored; resp_valid=0 cycles hold state.
- abort in RUN → IDLE; done=0, pass=0, signature/pat_cnt frozen. abort has priority over resp_valid in the same cycle. abort in IDLE/DONE has no effect.
- DONE: resp_valid ignored; start → RUN (re-seed, clear pat_cnt, done←0, pass←0).
- pat_cnt saturates at NUM_PAT; no wrap.

## Timing
- Reset values: busy=0, done=0, pass=0, signature=SEED, pat_cnt=0, state IDLE.
- start→busy: 1 cycle (busy high the cycle after start is sampled).
- A vector accepted at edge k is reflected in signature after edge k.
- done and pass rise together one cycle after the last vector is sampled; busy falls in that same cycle.
- NUM_PAT back-to-back valid cycles give a minimum run of NUM_PAT+1 cycles from start to done.
- Reset asserted mid-run forces reset values immediately (asynchronously); no partial result is retained.

## Configuration
- C17_SA_ONES_EN defined: adds a parallel ones-counter (width clog2(NUM_PAT·RESP_W+1)) that counts set resp bits on each accepted vector. Adds input golden_ones and output ones_cnt. ones_cnt clears on start and resets to 0. pass additionally requires ones_cnt==golden_ones.
- C17_SA_ONES_EN undefined: no counter and no extra ports; pass depends on the signature only.

## Structure
- Shared package c17_bist_pkg holds the state enum (IDLE/RUN/DONE), default POLY/SEED constants, and the signature width typedef. The pattern-source block uses the same package.
- One sub-module, c17_misr: a purely sequential register with load and enable, parameterised by SIG_W/POLY/RESP_W. The FSM and counters live in the top.

## Test plan
- Reset: rst_n low → busy=0, done=0, pass=0, signature=16'hFFFF, pat_cnt=0.
- NUM_PAT=1, start, resp=2'b00 valid once, golden=16'hEFDF → signature=16'hEFDF, done=1 and pass=1 one cycle later.
- NUM_PAT=1, resp=2'b11, golden=16'hEFDF → signature=16'hEFDC, done=1, pass=0.
- NUM_PAT=64, resp_valid toggled every other cycle → done exactly after the 64th valid vector; pat_cnt=64; start during RUN has no effect.
- abort coinciding with resp_valid after 10 vectors → IDLE, pat_cnt=10, done=0. A fresh start re-seeds to 16'hFFFF.
- Async reset mid-run (pat_cnt=30) → all outputs return to reset values within the same cycle. With C17_SA_ONES_EN defined and 64 vectors of 2'b01 with golden_ones=64 → ones_cnt=64, pass follows the signature match.
